// File: rtl/turfio_align_pkg.sv
// ----------------------------------------------------------------------------
// turfio_align_pkg
// Shared types for the CIN auto-alignment sequencer.
//   align_state_t : sequencer state encoding
//   TAP_W         : IDELAY tap value width
//   eye_result_t  : chosen eye centre and width (in sweep points)
//   clip_tap()    : clip a 10-bit intermediate tap value to the 9-bit range
// ----------------------------------------------------------------------------
package turfio_align_pkg;

    localparam int TAP_W = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_VTC_OFF,
        ST_LOAD,
        ST_SETTLE,
        ST_DWELL,
        ST_NEXT,
        ST_EVAL,
        ST_CLOAD,
        ST_CSETTLE,
        ST_SLIP_RST,
        ST_LOCK,
        ST_CHECK,
        ST_SLIP_WAIT,
        ST_DONE,
        ST_FAIL
    } align_state_t;

    typedef struct packed {
        logic [TAP_W-1:0] center;
        logic [6:0]       width;
    } eye_result_t;

    // Tap arithmetic is carried one bit wider so that overflow past 511
    // can be detected and pinned to the top tap instead of wrapping.
    function automatic logic [TAP_W-1:0] clip_tap(input logic [TAP_W:0] v);
        return v[TAP_W] ? {TAP_W{1'b1}} : v[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/cin_eye_tracker.sv
// ----------------------------------------------------------------------------
// cin_eye_tracker
// Tracks the longest contiguous run of good sweep points during a tap sweep.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr           : clear all run state (start of a new sweep)
//   sample_valid  : one-cycle strobe, 'good'/'tap' describe one sweep point
//   good          : the sampled tap was error-free
//   tap           : tap value of the sampled point
//   best_start    : first tap of the longest run (includes a still-open run)
//   best_len      : length of the longest run in sweep points
// ----------------------------------------------------------------------------
module cin_eye_tracker
    import turfio_align_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_valid,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len
);

    logic [TAP_W-1:0] cur_start_q;
    logic [TAP_W:0]   cur_len_q;
    logic [TAP_W-1:0] best_start_q;
    logic [TAP_W:0]   best_len_q;

    // Run bookkeeping: a bad point closes the open run and promotes it only
    // when strictly longer, so on a tie the earlier run is kept.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (sample_valid) begin
            if (good) begin
                if (cur_len_q == '0) begin
                    cur_start_q <= tap;
                end
                cur_len_q <= cur_len_q + 1'b1;
            end else begin
                if (cur_len_q > best_len_q) begin
                    best_start_q <= cur_start_q;
                    best_len_q   <= cur_len_q;
                end
                cur_len_q <= '0;
            end
        end
    end

    // A run still open at the last tap competes here, so the consumer sees
    // the final answer without a separate closing step.
    always_comb begin
        best_start = best_start_q;
        best_len   = best_len_q;
        if (cur_len_q > best_len_q) begin
            best_start = cur_start_q;
            best_len   = cur_len_q;
        end
    end

endmodule

// File: rtl/turfio_cin_autoalign.sv
// ----------------------------------------------------------------------------
// turfio_cin_autoalign
// Hardware sequencer aligning the SURF CIN receive path: sweeps the IDELAY
// tap, centres on the widest error-free eye, then bitslips the parallelizer
// until it locks on the training pattern.
// Ports:
//   wb_clk_i, wb_rst_i   : clock, synchronous active-high reset
//   start_i, abort_i     : begin alignment / abandon (abort wins)
//   cin_err_i            : CIN bit-error flag (synchronized level)
//   lock_status_i        : parallelizer locked (synchronized)
//   delay_load_o         : one-cycle IDELAY load strobe
//   delay_cntvaluein_o   : tap value to load
//   en_vtc_o             : IDELAY VT compensation enable
//   bitslip_rst_o, bitslip_o, lock_req_o : one-cycle parallelizer strobes
//   busy_o, done_o, fail_o               : status (done/fail sticky)
//   eye_center_o, eye_width_o, slips_o   : alignment result
//   scan_map_o           : per-point good map (only with CIN_AUTOALIGN_MAP_EN)
// Optional feature macro: CIN_AUTOALIGN_MAP_EN
// ----------------------------------------------------------------------------
module turfio_cin_autoalign
    import turfio_align_pkg::*;
#(
    parameter int TAP_STEP      = 8,
    parameter int TAP_MAX       = 504,
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 1024,
    parameter int MIN_EYE       = 4,
    parameter int MAX_SLIPS     = 8,
    parameter int LOCK_WAIT     = 64
)
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cin_err_i,
    input  logic             lock_status_i,
    output logic             delay_load_o,
    output logic [TAP_W-1:0] delay_cntvaluein_o,
    output logic             en_vtc_o,
    output logic             bitslip_rst_o,
    output logic             bitslip_o,
    output logic             lock_req_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [TAP_W-1:0] eye_center_o,
    output logic [6:0]       eye_width_o,
    output logic [3:0]       slips_o
`ifdef CIN_AUTOALIGN_MAP_EN
    ,
    output logic [TAP_MAX/TAP_STEP:0] scan_map_o
`endif
);

    localparam int NPTS = TAP_MAX / TAP_STEP + 1;

    localparam logic [TAP_W:0] STEP_W    = (TAP_W+1)'(TAP_STEP);
    localparam logic [TAP_W:0] MAX_W     = (TAP_W+1)'(TAP_MAX);
    localparam logic [TAP_W:0] NPTS_W    = (TAP_W+1)'(NPTS);
    localparam logic [TAP_W:0] MIN_W     = (TAP_W+1)'(MIN_EYE);
    localparam logic [TAP_W:0] ALL_GOOD_C = (TAP_W+1)'(((TAP_MAX / 2) / TAP_STEP) * TAP_STEP);
    localparam logic [3:0]     SLIPS_MAX = 4'(MAX_SLIPS);

    localparam logic [31:0] VTC_LAST    = 32'd7;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST   = 32'(LOCK_WAIT - 1);

    align_state_t     state;
    logic [31:0]      cnt;
    logic [TAP_W:0]   tap_q;
    logic             err_seen;
    logic [3:0]       slips_q;
    eye_result_t      eye_q;

    logic             trk_clr;
    logic             trk_valid;
    logic [TAP_W-1:0] trk_start;
    logic [TAP_W:0]   trk_len;
    logic [TAP_W:0]   span;
    logic [TAP_W:0]   center_raw;
    logic [6:0]       width_sat;

    assign trk_clr   = (state == ST_IDLE) && start_i && !abort_i;
    assign trk_valid = (state == ST_NEXT);

    cin_eye_tracker u_tracker (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .clr          (trk_clr),
        .sample_valid (trk_valid),
        .good         (!err_seen),
        .tap          (tap_q[TAP_W-1:0]),
        .best_start   (trk_start),
        .best_len     (trk_len)
    );

    // Eye centre: half the run span added to its first tap. A fully clean
    // sweep has no edges to centre between, so it falls back to mid-range
    // rounded down to a sweep point.
    always_comb begin
        span       = ((trk_len - 1'b1) * STEP_W) >> 1;
        center_raw = {1'b0, trk_start} + span;
        if (trk_len == NPTS_W) begin
            center_raw = ALL_GOOD_C;
        end
        width_sat = (trk_len > (TAP_W+1)'(127)) ? 7'd127 : trk_len[6:0];
    end

    assign eye_center_o = eye_q.center;
    assign eye_width_o  = eye_q.width;
    assign slips_o      = slips_q;

    // Sequencer: strobes default low each cycle and are raised on the
    // transition into the state that owns them, so each lasts one cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            tap_q              <= '0;
            err_seen           <= 1'b0;
            slips_q            <= '0;
            eye_q              <= '0;
            delay_load_o       <= 1'b0;
            delay_cntvaluein_o <= '0;
            en_vtc_o           <= 1'b1;
            bitslip_rst_o      <= 1'b0;
            bitslip_o          <= 1'b0;
            lock_req_o         <= 1'b0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            fail_o             <= 1'b0;
        end else begin
            delay_load_o  <= 1'b0;
            bitslip_rst_o <= 1'b0;
            bitslip_o     <= 1'b0;
            lock_req_o    <= 1'b0;
            if (abort_i) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                en_vtc_o <= 1'b1;
                busy_o   <= 1'b0;
                done_o   <= 1'b0;
                fail_o   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            state    <= ST_VTC_OFF;
                            cnt      <= '0;
                            en_vtc_o <= 1'b0;
                            busy_o   <= 1'b1;
                            done_o   <= 1'b0;
                            fail_o   <= 1'b0;
                            eye_q    <= '0;
                            slips_q  <= '0;
                        end
                    end
                    ST_VTC_OFF: begin
                        if (cnt == VTC_LAST) begin
                            cnt                <= '0;
                            tap_q              <= '0;
                            delay_load_o       <= 1'b1;
                            delay_cntvaluein_o <= '0;
                            state              <= ST_LOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt      <= '0;
                            err_seen <= 1'b0;
                            state    <= ST_DWELL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (cin_err_i) begin
                            err_seen <= 1'b1;
                        end
                        if (cnt == DWELL_LAST) begin
                            cnt   <= '0;
                            state <= ST_NEXT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        if (tap_q == MAX_W) begin
                            state <= ST_EVAL;
                        end else begin
                            tap_q              <= tap_q + STEP_W;
                            delay_load_o       <= 1'b1;
                            delay_cntvaluein_o <= clip_tap(tap_q + STEP_W);
                            state              <= ST_LOAD;
                        end
                    end
                    ST_EVAL: begin
                        eye_q.width <= width_sat;
                        if (trk_len < MIN_W) begin
                            state <= ST_FAIL;
                        end else begin
                            eye_q.center       <= clip_tap(center_raw);
                            delay_load_o       <= 1'b1;
                            delay_cntvaluein_o <= clip_tap(center_raw);
                            state              <= ST_CLOAD;
                        end
                    end
                    ST_CLOAD: begin
                        cnt   <= '0;
                        state <= ST_CSETTLE;
                    end
                    ST_CSETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt           <= '0;
                            bitslip_rst_o <= 1'b1;
                            slips_q       <= '0;
                            state         <= ST_SLIP_RST;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SLIP_RST: begin
                        cnt        <= '0;
                        lock_req_o <= 1'b1;
                        state      <= ST_LOCK;
                    end
                    ST_LOCK: begin
                        if (cnt == LOCK_LAST) begin
                            cnt   <= '0;
                            state <= ST_CHECK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (lock_status_i) begin
                            state <= ST_DONE;
                        end else if (slips_q == SLIPS_MAX) begin
                            state <= ST_FAIL;
                        end else begin
                            bitslip_o <= 1'b1;
                            slips_q   <= slips_q + 1'b1;
                            cnt       <= '0;
                            state     <= ST_SLIP_WAIT;
                        end
                    end
                    ST_SLIP_WAIT: begin
                        if (cnt == LOCK_LAST) begin
                            cnt        <= '0;
                            lock_req_o <= 1'b1;
                            state      <= ST_LOCK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        en_vtc_o <= 1'b1;
                        state    <= ST_IDLE;
                    end
                    ST_FAIL: begin
                        fail_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        en_vtc_o <= 1'b1;
                        state    <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CIN_AUTOALIGN_MAP_EN
    // Per-point map: cleared when a sweep starts, one bit written per point.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || trk_clr) begin
            scan_map_o <= '0;
        end else if (trk_valid && !abort_i) begin
            for (int k = 0; k < NPTS; k++) begin
                if (tap_q == (TAP_W+1)'(k * TAP_STEP)) begin
                    scan_map_o[k] <= !err_seen;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_turfio_cin_autoalign.sv
// ----------------------------------------------------------------------------
// tb_turfio_cin_autoalign
// Directed bench for the CIN auto-alignment sequencer. A small channel model
// turns the loaded tap into cin_err_i and counts bitslips to produce
// lock_status_i. Short settle/dwell/lock windows keep each sweep brief.
// ----------------------------------------------------------------------------
module tb_turfio_cin_autoalign;

    localparam int TAP_STEP      = 8;
    localparam int TAP_MAX       = 504;
    localparam int SETTLE_CYCLES = 4;
    localparam int DWELL_CYCLES  = 8;
    localparam int MIN_EYE       = 3;
    localparam int MAX_SLIPS     = 8;
    localparam int LOCK_WAIT     = 4;
    localparam int BUDGET        = 5000;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       cin_err_i = 1'b1;
    logic       lock_status_i = 1'b0;
    logic       delay_load_o;
    logic [8:0] delay_cntvaluein_o;
    logic       en_vtc_o;
    logic       bitslip_rst_o;
    logic       bitslip_o;
    logic       lock_req_o;
    logic       busy_o;
    logic       done_o;
    logic       fail_o;
    logic [8:0] eye_center_o;
    logic [6:0] eye_width_o;
    logic [3:0] slips_o;

    int n_vec = 0;
    int n_mis = 0;

    // Channel model configuration, written by the test sequence.
    int m_lo1 = 1, m_hi1 = 0, m_lo2 = 1, m_hi2 = 0;
    bit m_noise = 1'b0;
    int m_need = 0;
    int since_load = 100;
    int bs_count = 0;
    bit armed = 1'b0;

    typedef struct {
        int lo1;
        int hi1;
        int lo2;
        int hi2;
        bit noise;
        int lock_need;
        bit exp_done;
        int exp_center;
        int exp_width;
        int exp_slips;
    } vec_t;

    vec_t vecs[11];

    always #5 wb_clk_i = ~wb_clk_i;

    turfio_cin_autoalign #(
        .TAP_STEP      (TAP_STEP),
        .TAP_MAX       (TAP_MAX),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .DWELL_CYCLES  (DWELL_CYCLES),
        .MIN_EYE       (MIN_EYE),
        .MAX_SLIPS     (MAX_SLIPS),
        .LOCK_WAIT     (LOCK_WAIT)
    ) dut (
        .wb_clk_i           (wb_clk_i),
        .wb_rst_i           (wb_rst_i),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .cin_err_i          (cin_err_i),
        .lock_status_i      (lock_status_i),
        .delay_load_o       (delay_load_o),
        .delay_cntvaluein_o (delay_cntvaluein_o),
        .en_vtc_o           (en_vtc_o),
        .bitslip_rst_o      (bitslip_rst_o),
        .bitslip_o          (bitslip_o),
        .lock_req_o         (lock_req_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .fail_o             (fail_o),
        .eye_center_o       (eye_center_o),
        .eye_width_o        (eye_width_o),
        .slips_o            (slips_o)
    );

    // Channel model: error-free only inside the configured tap windows;
    // optional noise lands exactly in the settle cycles after each load.
    // Lock appears once enough bitslips follow the last bitslip reset.
    always @(negedge wb_clk_i) begin
        int  tapv;
        bit  good;
        if (wb_rst_i) begin
            since_load = 100;
            bs_count   = 0;
            armed      = 1'b0;
        end else begin
            if (delay_load_o) since_load = 0;
            else if (since_load < 100) since_load++;
            if (bitslip_rst_o) begin
                bs_count = 0;
                armed    = 1'b0;
            end
            if (bitslip_o) bs_count++;
            if (lock_req_o) armed = 1'b1;
        end
        tapv = int'(delay_cntvaluein_o);
        good = (tapv >= m_lo1 && tapv <= m_hi1) || (tapv >= m_lo2 && tapv <= m_hi2);
        cin_err_i = !good || (m_noise && since_load >= 1 && since_load <= SETTLE_CYCLES);
        lock_status_i = armed && (bs_count >= m_need);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives start/abort for one clock; called and returns on a falling edge.
    task automatic applyStimulus(input bit s, input bit a);
        start_i = s;
        abort_i = a;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic setModel(input int lo1, input int hi1, input int lo2, input int hi2,
                            input bit noise, input int need);
        m_lo1 = lo1; m_hi1 = hi1; m_lo2 = lo2; m_hi2 = hi2;
        m_noise = noise;
        m_need = need;
    endtask

    task automatic waitLoads(input int n, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < BUDGET) begin
            @(negedge wb_clk_i);
            cyc++;
            if (delay_load_o) seen++;
        end
        if (seen < n) checkOutput({name, "_timeout"}, 32'(seen), 32'(n));
    endtask

    task automatic runVector(input int i);
        int cyc;
        string tag;
        tag = $sformatf("v%0d", i);
        setModel(vecs[i].lo1, vecs[i].hi1, vecs[i].lo2, vecs[i].hi2, vecs[i].noise, vecs[i].lock_need);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, "_busy_after_start"}, 32'(busy_o), 32'd1);
        checkOutput({tag, "_done_cleared"}, 32'(done_o | fail_o), 32'd0);
        cyc = 0;
        while (!(done_o || fail_o) && cyc < BUDGET) begin
            @(negedge wb_clk_i);
            cyc++;
        end
        checkOutput({tag, "_finished_in_budget"}, 32'(done_o || fail_o), 32'd1);
        checkOutput({tag, "_done"}, 32'(done_o), 32'(vecs[i].exp_done));
        checkOutput({tag, "_fail"}, 32'(fail_o), 32'(!vecs[i].exp_done));
        checkOutput({tag, "_center"}, 32'(eye_center_o), 32'(vecs[i].exp_center));
        checkOutput({tag, "_width"}, 32'(eye_width_o), 32'(vecs[i].exp_width));
        checkOutput({tag, "_slips"}, 32'(slips_o), 32'(vecs[i].exp_slips));
        checkOutput({tag, "_en_vtc"}, 32'(en_vtc_o), 32'd1);
        checkOutput({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int loads;
        int vtc_low;

        //          lo1  hi1  lo2  hi2  noise need done ctr  wid slips
        vecs[0]  = '{80,  200, 1,   0,   1'b0, 0,  1'b1, 140, 16, 0};
        vecs[1]  = '{1,   0,   1,   0,   1'b0, 0,  1'b0, 0,   0,  0};
        vecs[2]  = '{40,  72,  300, 400, 1'b0, 0,  1'b1, 352, 13, 0};
        vecs[3]  = '{8,   32,  304, 328, 1'b0, 0,  1'b1, 20,  4,  0};
        vecs[4]  = '{80,  200, 1,   0,   1'b0, 3,  1'b1, 140, 16, 3};
        vecs[5]  = '{80,  200, 1,   0,   1'b0, 99, 1'b0, 140, 16, 8};
        vecs[6]  = '{488, 504, 1,   0,   1'b0, 0,  1'b1, 496, 3,  0};
        vecs[7]  = '{496, 504, 1,   0,   1'b0, 0,  1'b0, 0,   2,  0};
        vecs[8]  = '{0,   504, 1,   0,   1'b0, 0,  1'b1, 248, 64, 0};
        vecs[9]  = '{80,  200, 1,   0,   1'b1, 0,  1'b1, 140, 16, 0};
        vecs[10] = '{0,   16,  1,   0,   1'b0, 1,  1'b1, 8,   3,  1};

        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("rst_en_vtc", 32'(en_vtc_o), 32'd1);
        checkOutput("rst_strobes", 32'({delay_load_o, bitslip_rst_o, bitslip_o, lock_req_o}), 32'd0);
        checkOutput("rst_flags", 32'({busy_o, done_o, fail_o}), 32'd0);
        checkOutput("rst_eye", 32'({eye_center_o, eye_width_o}), 32'd0);
        checkOutput("rst_slips", 32'(slips_o), 32'd0);
        checkOutput("rst_cntvalue", 32'(delay_cntvaluein_o), 32'd0);

        for (int i = 0; i < 11; i++) begin
            runVector(i);
        end

        // Abort clears a sticky done flag.
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_clears_done", 32'({done_o, fail_o}), 32'd0);

        // Start and abort together: abort wins, sequencer never leaves idle.
        setModel(80, 200, 1, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("start_abort_busy", 32'(busy_o), 32'd0);
        loads = 0;
        vtc_low = 0;
        repeat (40) begin
            @(negedge wb_clk_i);
            if (delay_load_o) loads++;
            if (!en_vtc_o) vtc_low++;
        end
        checkOutput("start_abort_no_load", 32'(loads), 32'd0);
        checkOutput("start_abort_vtc_held", 32'(vtc_low), 32'd0);

        // Abort mid-dwell: first load is cycle 0, dwell spans cycles 5..12.
        applyStimulus(1'b1, 1'b0);
        waitLoads(1, "abort_first_load");
        repeat (7) @(negedge wb_clk_i);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_en_vtc", 32'(en_vtc_o), 32'd1);
        checkOutput("abort_flags", 32'({done_o, fail_o}), 32'd0);
        loads = 0;
        repeat (60) begin
            @(negedge wb_clk_i);
            if (delay_load_o || bitslip_o || bitslip_rst_o || lock_req_o) loads++;
        end
        checkOutput("abort_no_strobes", 32'(loads), 32'd0);

        // Reset in the middle of a sweep behaves like power-on reset.
        applyStimulus(1'b1, 1'b0);
        waitLoads(3, "reset_sweep_load");
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("midrst_en_vtc", 32'(en_vtc_o), 32'd1);
        checkOutput("midrst_flags", 32'({busy_o, done_o, fail_o}), 32'd0);
        checkOutput("midrst_cntvalue", 32'(delay_cntvaluein_o), 32'd0);
        wb_rst_i = 1'b0;
        loads = 0;
        repeat (30) begin
            @(negedge wb_clk_i);
            if (delay_load_o) loads++;
        end
        checkOutput("midrst_idle", 32'(loads), 32'd0);
        runVector(0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
